// File: rtl/alu_sequencer.sv
// Micro-sequencer for the shared 4-register/ALU datapath: holds a bus-loaded
// program of ALU instructions and issues them in order, with optional repeats.
module alu_sequencer #(
    parameter int PROG_DEPTH = 8,
    parameter int REP_W      = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_write,
    input  logic [3:0] cfg_addr,
    input  logic [7:0] cfg_data,
    output logic [7:0] cfg_rdata,
    output logic [1:0] alu_sel_a,
    output logic [1:0] alu_sel_b,
    output logic [3:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       wb_en,
    output logic [1:0] wb_sel,
    output logic [7:0] wb_data,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WB, S_DONE} state_t;

    localparam logic [2:0] PC_LAST = 3'(PROG_DEPTH - 1);

    state_t           state, state_nx;
    logic [7:0]       prog [PROG_DEPTH];
    logic [2:0]       pc, pc_nx;
    logic [REP_W-1:0] iter, iter_nx;
    logic             aborted, wr_err;
    logic [7:0]       instr;
    logic             running, wr_ctl, slot_wr, abort_req, start_req, clear_req;
    logic             rep_or_start, pass_end;

    assign instr        = prog[pc];
    assign running      = (state != S_IDLE);
    assign wr_ctl       = cfg_write && (cfg_addr == 4'h8);
    assign slot_wr      = cfg_write && (int'(cfg_addr) < PROG_DEPTH);
    assign abort_req    = wr_ctl && cfg_data[1];
    assign start_req    = wr_ctl && cfg_data[0] && !cfg_data[1] && (state == S_IDLE);
    assign clear_req    = wr_ctl && cfg_data[2];
    assign rep_or_start = cfg_data[0] || (|cfg_data[4 +: REP_W]);
    assign pass_end     = instr[7] || (pc == PC_LAST);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        iter_nx  = iter;
        case (state)
            S_IDLE: begin
                if (start_req) begin
                    state_nx = S_ISSUE;
                    pc_nx    = '0;
                    iter_nx  = cfg_data[4 +: REP_W];
                end
            end
            S_ISSUE: state_nx = S_WB;
            S_WB: begin
                if (!pass_end) begin
                    pc_nx    = pc + 3'd1;
                    state_nx = S_ISSUE;
                end else if (iter == '0) begin
                    state_nx = S_DONE;
                end else begin
                    iter_nx  = iter - 1'b1;
                    pc_nx    = '0;
                    state_nx = S_ISSUE;
                end
            end
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        // Abort overrides whatever the run was about to do.
        if (abort_req) state_nx = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pc        <= '0;
            iter      <= '0;
            alu_sel_a <= '0;
            alu_sel_b <= '0;
            alu_op    <= '0;
            for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            iter  <= iter_nx;
            if (state == S_ISSUE) begin
                alu_sel_a <= instr[1:0];
                alu_sel_b <= instr[3:2];
                alu_op    <= {3'b000, instr[6]};
            end
            if (slot_wr && !running) prog[cfg_addr[2:0]] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            aborted <= 1'b0;
            wr_err  <= 1'b0;
        end else begin
            if (clear_req || start_req) begin
                done    <= 1'b0;
                aborted <= 1'b0;
            end
            if (state == S_DONE && !abort_req) done <= 1'b1;
            if (abort_req) aborted <= 1'b1;
            // Edits to the program or run setup during a run are dropped and flagged.
            if (cfg_write && cfg_addr == 4'h9)
                wr_err <= 1'b0;
            else if (running && (slot_wr || (wr_ctl && !cfg_data[1] && rep_or_start)))
                wr_err <= 1'b1;
        end
    end

    assign busy    = (state == S_ISSUE) || (state == S_WB);
    assign wb_en   = (state == S_WB) && !abort_req;
    assign wb_sel  = (state == S_WB) ? instr[5:4] : 2'b00;
    assign wb_data = wb_en ? alu_result : 8'h00;

    always_comb begin
        cfg_rdata = 8'h00;
        if (int'(cfg_addr) < PROG_DEPTH)
            cfg_rdata = prog[cfg_addr[2:0]];
        else if (cfg_addr == 4'h9)
            cfg_rdata = {1'b0, pc, wr_err, aborted, done, busy};
    end

endmodule
